decryption_r2: RTL and testbench

- Receiver-side counterpart of the R2 encryption stage in the Diffie-Hellman datapath.
- Computes the shared key k = pub^priv mod p with a constant-time, bit-serial square-and-multiply engine.
- Recovers the plaintext as r2 = c1 XOR k.
- Sits after the key-exchange receive path. Reports completion with a one-cycle done pulse.

---
 rtl/decryption_r2_pkg.sv | 23 ++
 rtl/decryption_r2_if.sv | 29 ++
 rtl/decryption_r2_mod_mul_serial.sv | 90 +++++++++
 rtl/decryption_r2.sv | 196 +++++++++++++++++++
 tb/tb_decryption_r2.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/decryption_r2_pkg.sv
// Shared Diffie-Hellman definitions: default widths, FSM encoding and the
// operand error classes common to the encryption and decryption stages.
package decryption_r2_pkg;

    localparam int DH_W     = 32;
    localparam int DH_EXP_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SQR    = 3'd2,
        ST_MUL    = 3'd3,
        ST_FINISH = 3'd4
    } dh_state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_P_SMALL   = 2'd1,
        ERR_PUB_ZERO  = 2'd2,
        ERR_PUB_RANGE = 2'd3
    } dh_err_e;

endpackage

// File: rtl/decryption_r2_if.sv
// Request/response bundle of the R2 decryption stage; the requester drives
// the master side, decryption_r2 sits on the slave side.
interface decryption_r2_if
    import decryption_r2_pkg::*;
#(
    parameter int W     = DH_W,
    parameter int EXP_W = DH_EXP_W
);
    logic             start_i;
    logic [W-1:0]     c1_i;
    logic [W-1:0]     pub_i;
    logic [EXP_W-1:0] priv_i;
    logic [W-1:0]     p_i;
    logic             busy_o;
    logic             done_dec;
    logic             err_o;
    logic [W-1:0]     k_o;
    logic [W-1:0]     r2_o;

    modport master (
        output start_i, c1_i, pub_i, priv_i, p_i,
        input  busy_o, done_dec, err_o, k_o, r2_o
    );

    modport slave (
        input  start_i, c1_i, pub_i, priv_i, p_i,
        output busy_o, done_dec, err_o, k_o, r2_o
    );
endinterface

// File: rtl/decryption_r2_mod_mul_serial.sv
// Bit-serial interleaved modular multiplier: result = a*b mod p, MSB-first,
// one load edge plus W iteration edges, then a one-cycle done pulse.
module mod_mul_serial
    import decryption_r2_pkg::*;
#(
    parameter int W = DH_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    output logic         done,
    output logic [W-1:0] result
);
    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     p_q, p_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;

    // Both reductions work on W+1 bits so 2*acc and acc+a never overflow;
    // callers guarantee acc < p and a < p.
    function automatic logic [W-1:0] mm_step(input logic [W-1:0] acc_v,
                                             input logic [W-1:0] a_v,
                                             input logic [W-1:0] p_v,
                                             input logic         m_bit);
        logic [W:0] t;
        t = {acc_v, 1'b0};
        if (t >= {1'b0, p_v}) t = t - {1'b0, p_v};
        if (m_bit)            t = t + {1'b0, a_v};
        if (t >= {1'b0, p_v}) t = t - {1'b0, p_v};
        return t[W-1:0];
    endfunction

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        p_d    = p_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            a_d   = a;
            b_d   = b;
            p_d   = p;
            acc_d = '0;
            cnt_d = CNT_W'(W);
            run_d = 1'b1;
        end else if (run_q) begin
            acc_d = mm_step(acc_q, a_q, p_q, b_q[W-1]);
            b_d   = {b_q[W-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            p_q    <= p_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done   = done_q;
    assign result = acc_q;

endmodule

// File: rtl/decryption_r2.sv
// R2 decryption: k = pub^priv mod p by constant-time square-and-multiply,
// r2 = c1 ^ k. Optional macro DEC_KEY_OUT_EN exposes k on k_o (else k_o = 0).
module decryption_r2
    import decryption_r2_pkg::*;
#(
    parameter int W     = DH_W,
    parameter int EXP_W = DH_EXP_W
) (
    input  logic           clk,
    input  logic           rst,
    decryption_r2_if.slave bus
);
    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    dh_state_e        state_q, state_d;
    logic [W-1:0]     c1_q, c1_d;
    logic [W-1:0]     pub_q, pub_d;
    logic [W-1:0]     p_q, p_d;
    logic [EXP_W-1:0] priv_q, priv_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0] bit_q, bit_d;
    logic             err_pend_q, err_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [W-1:0]     r2_q, r2_d;
`ifdef DEC_KEY_OUT_EN
    logic [W-1:0]     k_q, k_d;
`endif

    logic             mm_start;
    logic [W-1:0]     mm_a, mm_b;
    logic             mm_done;
    logic [W-1:0]     mm_res;

    function automatic dh_err_e check_operands(input logic [W-1:0] p_v,
                                               input logic [W-1:0] pub_v);
        if (p_v < W'(2))    return ERR_P_SMALL;
        if (pub_v == '0)    return ERR_PUB_ZERO;
        if (pub_v >= p_v)   return ERR_PUB_RANGE;
        return ERR_NONE;
    endfunction

    mod_mul_serial #(.W(W)) u_mm (
        .clk    (clk),
        .rst    (rst),
        .start  (mm_start),
        .a      (mm_a),
        .b      (mm_b),
        .p      (p_q),
        .done   (mm_done),
        .result (mm_res)
    );

    always_comb begin
        state_d    = state_q;
        c1_d       = c1_q;
        pub_d      = pub_q;
        p_d        = p_q;
        priv_d     = priv_q;
        acc_d      = acc_q;
        bit_d      = bit_q;
        err_pend_d = err_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        r2_d       = r2_q;
`ifdef DEC_KEY_OUT_EN
        k_d        = k_q;
`endif
        mm_start   = 1'b0;
        mm_a       = acc_q;
        mm_b       = acc_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    c1_d       = bus.c1_i;
                    pub_d      = bus.pub_i;
                    p_d        = bus.p_i;
                    priv_d     = bus.priv_i;
                    acc_d      = '0;
                    err_pend_d = 1'b0;
                    busy_d     = 1'b1;
                    r2_d       = '0;
`ifdef DEC_KEY_OUT_EN
                    k_d        = '0;
`endif
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (check_operands(p_q, pub_q) != ERR_NONE) begin
                    err_pend_d = 1'b1;
                    state_d    = ST_FINISH;
                end else begin
                    acc_d    = W'(1);
                    bit_d    = IDX_W'(EXP_W - 1);
                    mm_start = 1'b1;
                    mm_a     = W'(1);
                    mm_b     = W'(1);
                    state_d  = ST_SQR;
                end
            end
            ST_SQR: begin
                if (mm_done) begin
                    acc_d    = mm_res;
                    mm_start = 1'b1;
                    mm_a     = pub_q;
                    mm_b     = mm_res;
                    state_d  = ST_MUL;
                end
            end
            ST_MUL: begin
                // The product is always computed; only its use depends on the key bit.
                if (mm_done) begin
                    if (priv_q[bit_q]) acc_d = mm_res;
                    if (bit_q == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        bit_d    = bit_q - IDX_W'(1);
                        mm_start = 1'b1;
                        mm_a     = acc_d;
                        mm_b     = acc_d;
                        state_d  = ST_SQR;
                    end
                end
            end
            ST_FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (err_pend_q) begin
                    err_d = 1'b1;
                    r2_d  = '0;
`ifdef DEC_KEY_OUT_EN
                    k_d   = '0;
`endif
                end else begin
                    r2_d  = c1_q ^ acc_q;
`ifdef DEC_KEY_OUT_EN
                    k_d   = acc_q;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            c1_q       <= '0;
            pub_q      <= '0;
            p_q        <= '0;
            priv_q     <= '0;
            acc_q      <= '0;
            bit_q      <= '0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            r2_q       <= '0;
`ifdef DEC_KEY_OUT_EN
            k_q        <= '0;
`endif
        end else begin
            state_q    <= state_d;
            c1_q       <= c1_d;
            pub_q      <= pub_d;
            p_q        <= p_d;
            priv_q     <= priv_d;
            acc_q      <= acc_d;
            bit_q      <= bit_d;
            err_pend_q <= err_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            r2_q       <= r2_d;
`ifdef DEC_KEY_OUT_EN
            k_q        <= k_d;
`endif
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_dec = done_q;
    assign bus.err_o    = err_q;
    assign bus.r2_o     = r2_q;
`ifdef DEC_KEY_OUT_EN
    assign bus.k_o      = k_q;
`else
    assign bus.k_o      = '0;
`endif

endmodule

// File: tb/tb_decryption_r2.sv
// Bench for decryption_r2: directed vector table, randomized operations
// against a modular-exponentiation model, mid-operation start and reset abort.
module tb_decryption_r2;
    localparam int W       = 32;
    localparam int EXP_W   = 32;
    localparam int LAT     = 2 + 2 * EXP_W * (W + 1);
    localparam int ERR_LAT = 2;
    localparam int TIMEOUT = LAT + 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   key_seen = 1'b0;

    typedef struct {
        logic [31:0] c1;
        logic [31:0] pub;
        logic [31:0] priv;
        logic [31:0] p;
        logic [31:0] k;
        logic [31:0] r2;
        bit          err;
    } vec_t;

    decryption_r2_if #(.W(W), .EXP_W(EXP_W)) bus ();

    decryption_r2 #(.W(W), .EXP_W(EXP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Right-to-left binary exponentiation with 64-bit products.
    function automatic logic [31:0] ref_modexp(input logic [31:0] base, input logic [31:0] e,
                                               input logic [31:0] m);
        longint unsigned r, b, mm;
        mm = {32'd0, m};
        r  = 1;
        b  = {32'd0, base} % mm;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * b) % mm;
            b = (b * b) % mm;
        end
        return 32'(r % mm);
    endfunction

    function automatic vec_t make_vec(input logic [31:0] c1, input logic [31:0] pub,
                                      input logic [31:0] priv, input logic [31:0] p);
        vec_t v;
        v.c1   = c1;
        v.pub  = pub;
        v.priv = priv;
        v.p    = p;
        v.err  = (p < 2) || (pub == 0) || (pub >= p);
        v.k    = v.err ? 32'd0 : ref_modexp(pub, priv, p);
        v.r2   = v.err ? 32'd0 : (c1 ^ v.k);
        return v;
    endfunction

    task automatic run_op(input vec_t v, input bit inject);
        logic [31:0] exp_k;
        int          n;
        bit          seen;
`ifdef DEC_KEY_OUT_EN
        exp_k = v.k;
`else
        exp_k = 32'd0;
`endif
        @(negedge clk);
        bus.c1_i    = v.c1;
        bus.pub_i   = v.pub;
        bus.priv_i  = v.priv;
        bus.p_i     = v.p;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        check("busy_after_start", bus.busy_o, 1);
        check("k_cleared", bus.k_o, 0);
        check("r2_cleared", bus.r2_o, 0);
        // Captured copies must be used, so scramble the live inputs.
        bus.c1_i   = $urandom;
        bus.pub_i  = $urandom;
        bus.priv_i = $urandom;
        bus.p_i    = $urandom;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.k_o != 0) key_seen = 1'b1;
            if (bus.done_dec) seen = 1'b1;
            if (inject && n == 50) begin
                bus.start_i = 1'b1;
                bus.p_i     = 32'd7;
                bus.pub_i   = 32'd3;
            end
            if (inject && n == 51) bus.start_i = 1'b0;
        end
        bus.start_i = 1'b0;
        check("done_seen", seen, 1);
        check("latency", n, v.err ? ERR_LAT : LAT);
        check("err_o", bus.err_o, v.err);
        check("busy_at_done", bus.busy_o, 0);
        check("k_o", bus.k_o, exp_k);
        check("r2_o", bus.r2_o, v.r2);
        @(posedge clk);
        #1;
        check("done_pulse_width", bus.done_dec, 0);
        check("err_pulse_width", bus.err_o, 0);
        check("r2_held", bus.r2_o, v.r2);
        check("k_held", bus.k_o, exp_k);
    endtask

    initial begin
        vec_t tbl[7];
        vec_t v;
        logic [31:0] p, pub;
        int   n;
        bit   seen;

        tbl[0] = '{c1: 32'hA7, pub: 32'd8, priv: 32'd15, p: 32'd23, k: 32'd2, r2: 32'hA5, err: 1'b0};
        tbl[1] = '{c1: 32'h10, pub: 32'd8, priv: 32'd0, p: 32'd23, k: 32'd1, r2: 32'h11, err: 1'b0};
        tbl[2] = '{c1: 32'h0, pub: 32'hFFFF_FFFA, priv: 32'd2, p: 32'hFFFF_FFFB,
                   k: 32'd1, r2: 32'd1, err: 1'b0};
        tbl[3] = '{c1: 32'h55, pub: 32'd5, priv: 32'd7, p: 32'd1, k: 32'd0, r2: 32'd0, err: 1'b1};
        tbl[4] = '{c1: 32'h55, pub: 32'd23, priv: 32'd7, p: 32'd23, k: 32'd0, r2: 32'd0, err: 1'b1};
        tbl[5] = '{c1: 32'h55, pub: 32'd0, priv: 32'd7, p: 32'd23, k: 32'd0, r2: 32'd0, err: 1'b1};
        tbl[6] = '{c1: 32'h55, pub: 32'd3, priv: 32'd7, p: 32'd0, k: 32'd0, r2: 32'd0, err: 1'b1};

        bus.start_i = 1'b0;
        bus.c1_i    = '0;
        bus.pub_i   = '0;
        bus.priv_i  = '0;
        bus.p_i     = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_dec, 0);
        check("rst_err", bus.err_o, 0);
        check("rst_k", bus.k_o, 0);
        check("rst_r2", bus.r2_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_op(tbl[i], i == 0);

        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) p = $urandom_range(1000, 2);
            else            p = $urandom | 32'h8000_0000;
            if (i == 7) pub = p;
            else        pub = 32'd1 + ($urandom % (p - 32'd1));
            v = make_vec($urandom, pub, $urandom, p);
            run_op(v, 1'b0);
        end

        // Reset in the middle of an operation aborts it without a done pulse.
        @(negedge clk);
        bus.c1_i    = tbl[0].c1;
        bus.pub_i   = tbl[0].pub;
        bus.priv_i  = tbl[0].priv;
        bus.p_i     = tbl[0].p;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", bus.busy_o, 0);
        check("abort_done", bus.done_dec, 0);
        check("abort_err", bus.err_o, 0);
        check("abort_k", bus.k_o, 0);
        check("abort_r2", bus.r2_o, 0);
        seen = 1'b0;
        n    = 0;
        while (n < LAT + 100) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done_dec || bus.busy_o) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        run_op(tbl[0], 1'b0);

`ifndef DEC_KEY_OUT_EN
        check("key_never_out", key_seen, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
